bsg_link_upstream_ch_sender: RTL
================================

Name: bsg_link_upstream_ch_sender

Overview:
- Single-channel link transmitter that feeds the downstream DDR receiver channel: accepts core words over a valid/ready handshake, serializes each word into narrow io flits, and drives io_valid_o/io_data_o toward the receiver's io_data_i/io_valid_i.
- Enforces credit-based flow control against the receiver's 64-entry buffer, replenished by the receiver's toggling token signal (core_token_r_o on the receive side).
- Single clock domain; io-side DDR launch is handled by a separate PHY wrapper.

Parameters:
- width_p, 16, core word width in bits.
- channel_width_p, 8, io flit width; width_p must be an integer multiple of it.
- lg_fifo_depth_p, 6, log2 of receiver buffer depth; initial credit count = 2**lg_fifo_depth_p.
- lg_credit_to_token_decimation_p, 3, each token rising edge returns 2**lg_credit_to_token_decimation_p credits.

Ports:
- core_clk_i  input  1  sole clock.
- core_link_reset_n_i  input  1  asynchronous, active-low reset.
- core_data_i  input  width_p  word to send.
- core_valid_i  input  1  core word valid.
- core_ready_o  output  1  block accepts the word this cycle.
- token_i  input  1  toggling token from receiver, asynchronous to core_clk_i.
- io_data_o  output  channel_width_p  current flit.
- io_valid_o  output  1  flit valid.
- credit_o  output  lg_fifo_depth_p+1  current credit count, for debug.
- error_o  output  1  sticky credit-overflow flag.

Behaviour:
- Reset is asynchronous and active-low. While core_link_reset_n_i=0:
  - io_valid_o=0, io_data_o=0, core_ready_o=0, error_o=0.
  - credit counter = 2**lg_fifo_depth_p (64); FSM = IDLE; synchronizer flops = 0.
- Asserting reset mid-word aborts the word immediately. No flit completion. Credit is restored to 64.
- Flits per word: N = width_p/channel_width_p (default 2). Flits go LSB-first.
- FSM states IDLE and SEND. Flit index counter spans 0..N-1.
  - IDLE to SEND on accept. The word is latched and index is set to 0.
  - In SEND: io_valid_o=1 and io_data_o = slice[index]. Index increments each cycle.
  - At index N-1: re-load and stay in SEND if a word is accepted that cycle; otherwise go to IDLE.
- core_ready_o = reset deasserted && (state==IDLE || index==N-1) && credit!=0. It is combinational from registered state only; there is no dependence on core_valid_i.
- Accept = core_valid_i && core_ready_o.
- Latency: word accepted at cycle t gives flit0 at t+1 and flit N-1 at t+N. Back-to-back words produce flits with no bubble.
- Credit decrements by 1 per accepted word. A word is one receiver buffer entry.
- Token handling:
  - token_i passes through a 2-flop synchronizer, then a third flop for edge detect.
  - A rising edge of the synced token adds 2**lg_credit_to_token_decimation_p (8).
  - Minimum token-edge-to-credit latency is 3 cycles.
- Simultaneous accept and token edge in the same cycle: credit += 7 (net).
- Credit counter width is lg_fifo_depth_p+1 bits (0..64).
- Overflow: a result above 64 saturates at 64 and sets error_o, which holds until reset.
- Underflow is impossible because ready_o is gated by credit!=0.
- Falling edges of token_i are ignored.

Decomposition:
- Shared package bsg_link_pkg holds:
  - state typedef (IDLE, SEND);
  - a function computing initial credits from lg_fifo_depth_p;
  - the token decimation constant.
- One sub-module: bsg_link_credit_counter. It contains the token synchronizer, edge detect, credit add/subtract, saturation and error_o.
- Serializer FSM stays in the top.

Test Plan:
- Reset check: hold reset low 3 cycles, then release. Expect io_valid_o=0, credit_o=64, core_ready_o=1 on the first cycle after release.
- Single word: accept core_data_i=0xBEEF at t. Expect io_data_o=0xEF at t+1 and 0xBE at t+2, both with io_valid_o=1, then io_valid_o=0 at t+3. credit_o=63.
- Streaming: core_valid_i held with 0x1111, 0x2222, 0x3333. Expect 6 consecutive valid flits 11,11,22,22,33,33 with no bubble; credit_o=61.
- Credit exhaustion and refill: send 64 words with token_i idle. Expect core_ready_o=0 after the 64th accept, credit_o=0. Then toggle token_i 0->1. Expect credit_o=8 and core_ready_o=1 three cycles later.
- Simultaneous events and overflow:
  - With credit_o=1, accept a word in the same cycle the synced token edge lands. Expect credit_o=8.
  - Then give 9 extra token edges without sending. Expect credit_o saturates at 64 and error_o=1 stays high.
- Mid-word reset: assert reset at the cycle flit0 of 0xA5C3 is driven. Expect io_valid_o=0 asynchronously (same cycle), no 0xA5 flit after release, and credit_o=64.

Source files
------------

// File: rtl/bsg_link_pkg.sv
// Shared types and constants for the upstream link sender and its credit counter.
package bsg_link_pkg;

    typedef enum logic {
        IDLE,
        SEND
    } state_e;

    // Each token rising edge returns 2**lg_token_decimation_lp credits.
    localparam int lg_token_decimation_lp = 3;

    function automatic int init_credits(input int lg_fifo_depth);
        return 1 << lg_fifo_depth;
    endfunction

endpackage

// File: rtl/bsg_link_credit_counter.sv
// Tracks receiver buffer credits: synchronizes the toggling token, adds credits
// on its rising edges, subtracts one per accepted word and flags overflow.
module bsg_link_credit_counter
    import bsg_link_pkg::*;
#(
    parameter int lg_fifo_depth_p                 = 6,
    parameter int lg_credit_to_token_decimation_p = lg_token_decimation_lp
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     token_i,
    input  logic                     accept_i,
    output logic [lg_fifo_depth_p:0] credit_o,
    output logic                     error_o
);

    localparam int cw_lp = lg_fifo_depth_p + 1;
    localparam logic [cw_lp-1:0] max_credit_lp = cw_lp'(init_credits(lg_fifo_depth_p));
    localparam logic [cw_lp:0]   inc_lp        = (cw_lp + 1)'(1 << lg_credit_to_token_decimation_p);

    logic [2:0]       sync_q, sync_d;
    logic [cw_lp-1:0] credit_q, credit_d;
    logic             error_q, error_d;
    logic             token_edge;
    logic [cw_lp:0]   sum_wide;

    // sync_q[1] is the synchronized token; sync_q[2] is its delayed copy for edge detect.
    assign token_edge = sync_q[1] & ~sync_q[2];

    always_comb begin
        sync_d   = {sync_q[1:0], token_i};
        sum_wide = {1'b0, credit_q} + (token_edge ? inc_lp : '0)
                   - {{cw_lp{1'b0}}, accept_i};
        credit_d = sum_wide[cw_lp-1:0];
        error_d  = error_q;
        if (sum_wide > {1'b0, max_credit_lp}) begin
            credit_d = max_credit_lp;
            error_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= '0;
            credit_q <= max_credit_lp;
            error_q  <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            credit_q <= credit_d;
            error_q  <= error_d;
        end
    end

    assign credit_o = credit_q;
    assign error_o  = error_q;

endmodule

// File: rtl/bsg_link_upstream_ch_sender.sv
// Upstream link channel sender: accepts core words under credit flow control and
// serializes each one LSB-first into channel-wide io flits.
module bsg_link_upstream_ch_sender
    import bsg_link_pkg::*;
#(
    parameter int width_p                         = 16,
    parameter int channel_width_p                 = 8,
    parameter int lg_fifo_depth_p                 = 6,
    parameter int lg_credit_to_token_decimation_p = lg_token_decimation_lp
) (
    input  logic                       core_clk_i,
    input  logic                       core_link_reset_n_i,
    input  logic [width_p-1:0]         core_data_i,
    input  logic                       core_valid_i,
    output logic                       core_ready_o,
    input  logic                       token_i,
    output logic [channel_width_p-1:0] io_data_o,
    output logic                       io_valid_o,
    output logic [lg_fifo_depth_p:0]   credit_o,
    output logic                       error_o
);

    localparam int num_flits_lp = width_p / channel_width_p;
    localparam int idx_w_lp     = (num_flits_lp > 1) ? $clog2(num_flits_lp) : 1;
    localparam logic [idx_w_lp-1:0] last_idx_lp = idx_w_lp'(num_flits_lp - 1);

    state_e                                         state_q, state_d;
    logic [idx_w_lp-1:0]                            idx_q, idx_d;
    logic [width_p-1:0]                             data_q, data_d;
    logic [num_flits_lp-1:0][channel_width_p-1:0]   flits;
    logic                                           accept;

    assign flits  = data_q;
    assign accept = core_valid_i & core_ready_o;

    // Ready depends only on registered state so the core never sees a comb loop.
    assign core_ready_o = core_link_reset_n_i
                          & ((state_q == IDLE) | (idx_q == last_idx_lp))
                          & (credit_o != '0);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SEND;
                    idx_d   = '0;
                    data_d  = core_data_i;
                end
            end
            SEND: begin
                if (idx_q == last_idx_lp) begin
                    if (accept) begin
                        idx_d  = '0;
                        data_d = core_data_i;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    idx_d = idx_q + idx_w_lp'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge core_clk_i or negedge core_link_reset_n_i) begin
        if (!core_link_reset_n_i) begin
            state_q <= IDLE;
            idx_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
        end
    end

    assign io_valid_o = (state_q == SEND);
    assign io_data_o  = io_valid_o ? flits[idx_q] : '0;

    bsg_link_credit_counter #(
        .lg_fifo_depth_p                (lg_fifo_depth_p),
        .lg_credit_to_token_decimation_p(lg_credit_to_token_decimation_p)
    ) credit_counter (
        .clk     (core_clk_i),
        .rst_n   (core_link_reset_n_i),
        .token_i (token_i),
        .accept_i(accept),
        .credit_o(credit_o),
        .error_o (error_o)
    );

endmodule
